// File: rtl/mba_rr.sv
// N-requester memory bus arbiter: fixed-priority or round-robin ownership of one data bus,
// with a bus-idle turnaround on every owner/direction change and a bounded tenure.
module mba_rr #(
   parameter int NUM_REQ    = 4,
   parameter int TURNAROUND = 3,
   parameter int MAX_HOLD   = 16,
   parameter int PRIO_MODE  = 1,
   localparam int OW        = $clog2(NUM_REQ)
) (
   input  logic               clk_166M66,
   input  logic               mcu_sys_rst_n,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [NUM_REQ-1:0] i_rw,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [OW-1:0]      o_bus_owner,
   output logic               o_data_bus_enable,
   output logic               o_data_bus_rw,
   output logic               o_preempt
);

   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
   localparam int TW = 4;

   typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_TURN} state_e;

   // Valid/ready is not used here: a requester holds i_req high until it sees its
   // o_grant bit; a request dropped before grant is lost.

   state_e               state_q, state_d;
   logic [OW-1:0]        owner_q, owner_d;
   logic                 rw_q, rw_d;
   logic [OW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [HW-1:0]        hold_q, hold_d;
   logic [TW-1:0]        turn_q, turn_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic                 enable_q, enable_d;
   logic                 preempt_q, preempt_d;

   logic [NUM_REQ-1:0]   others;
   logic [OW-1:0]        win_all, win_oth;
   logic                 any_req, any_other, hold_hit;

   function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] idx);
      if (int'(idx) == NUM_REQ - 1) return '0;
      return idx + 1'b1;
   endfunction

   // Round-robin scans upward from ptr with wrap; fixed priority scans from index 0.
   function automatic logic [OW-1:0] pick(input logic [NUM_REQ-1:0] req,
                                          input logic [OW-1:0]      ptr);
      logic [OW-1:0] win;
      logic [OW-1:0] idx;
      logic          found;
      win   = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (PRIO_MODE != 0) ? OW'((int'(ptr) + i) % NUM_REQ) : OW'(i);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      return win;
   endfunction

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rw_d      = rw_q;
      rr_ptr_d  = rr_ptr_q;
      hold_d    = hold_q;
      turn_d    = turn_q;
      preempt_d = 1'b0;

      others    = i_req & ~(NUM_REQ'(1) << owner_q);
      any_req   = |i_req;
      any_other = |others;
      win_all   = pick(i_req, rr_ptr_q);
      win_oth   = pick(others, rr_ptr_q);
      hold_hit  = (MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD - 1));

      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               state_d  = ST_GRANT;
               owner_d  = win_all;
               rw_d     = i_rw[win_all];
               rr_ptr_d = next_idx(win_all);
               hold_d   = '0;
            end
         end
         ST_GRANT: begin
            hold_d = (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
            if (!i_req[owner_q]) begin
               if (!any_other) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_TURN;
                  owner_d = win_oth;
                  rw_d    = i_rw[win_oth];
                  turn_d  = '0;
               end
            end else if (hold_hit && any_other) begin
               state_d   = ST_TURN;
               owner_d   = win_oth;
               rw_d      = i_rw[win_oth];
               turn_d    = '0;
               preempt_d = 1'b1;
            end else if (i_rw[owner_q] != rw_q) begin
               state_d = ST_TURN;
               rw_d    = i_rw[owner_q];
               turn_d  = '0;
            end
         end
         ST_TURN: begin
            // The window length is fixed; new requests only matter at its end.
            if (turn_q == TW'(TURNAROUND - 1)) begin
               if (i_req[owner_q]) begin
                  state_d  = ST_GRANT;
                  rw_d     = i_rw[owner_q];
                  rr_ptr_d = next_idx(owner_q);
                  hold_d   = '0;
               end else if (any_req) begin
                  state_d  = ST_GRANT;
                  owner_d  = win_all;
                  rw_d     = i_rw[win_all];
                  rr_ptr_d = next_idx(win_all);
                  hold_d   = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               turn_d = turn_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      enable_d = (state_d == ST_GRANT);
      grant_d  = enable_d ? (NUM_REQ'(1) << owner_d) : '0;
   end

   always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
      if (!mcu_sys_rst_n) begin
         state_q   <= ST_IDLE;
         owner_q   <= '0;
         rw_q      <= 1'b0;
         rr_ptr_q  <= '0;
         hold_q    <= '0;
         turn_q    <= '0;
         grant_q   <= '0;
         enable_q  <= 1'b0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         rw_q      <= rw_d;
         rr_ptr_q  <= rr_ptr_d;
         hold_q    <= hold_d;
         turn_q    <= turn_d;
         grant_q   <= grant_d;
         enable_q  <= enable_d;
         preempt_q <= preempt_d;
      end
   end

   assign o_grant           = grant_q;
   assign o_bus_owner       = owner_q;
   assign o_data_bus_enable = enable_q;
   assign o_data_bus_rw     = rw_q;
   assign o_preempt         = preempt_q;

endmodule
